// File: rtl/forward_scoreboard.sv
// ---------------------------------------------------------------------------
// forward_scoreboard
//
// Tracks the destination tags of the instructions in flight in the EX, MEM,
// WB, ... stages. From these tags it produces two results for the instruction
// in ID:
//   - a registered operand-select for each source, which EX uses on the
//     following cycle, and
//   - a combinational load-use stall request, raised when a source depends
//     on a load whose data is not yet forwardable.
//
// Parameters
//   REG_AW      GPR index width
//   DEPTH       number of tracked stages (2..7), entry k = stage k
//   LOAD_STAGE  first stage index whose load data is forwardable
//               (1..DEPTH-1)
//   SELW        select width, clog2(DEPTH+1)
//
// Ports
//   clk                          rising-edge clock
//   rst                          synchronous, active-low reset
//   idValid_i/idRegWrite_i/idIsLoad_i
//                                ID instruction qualifiers
//   idDstSpec_i/idDstId_i        ID destination (spec 0 = GPR, 1..3 = T/SP/IH)
//   srcAUse_i/srcASpec_i/srcAId_i  source A operand
//   srcBUse_i/srcBSpec_i/srcBId_i  source B operand
//   hold_i                       global freeze (highest priority)
//   flush_i                      kill the ID instruction
//   loadStall_o                  combinational load-use stall request
//   forwardA_o/forwardB_o        EX select: 0 = register file,
//                                k = stage k-1 pipeline register
//   stallCount_o                 saturating count of stall cycles
//                                (only with FWD_STALL_CNT_EN)
//
// Optional feature: define FWD_STALL_CNT_EN to add stallCount_o.
// ---------------------------------------------------------------------------
module forward_scoreboard #(
  parameter int REG_AW     = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idValid_i,
  input  logic              idRegWrite_i,
  input  logic              idIsLoad_i,
  input  logic [1:0]        idDstSpec_i,
  input  logic [REG_AW-1:0] idDstId_i,
  input  logic              srcAUse_i,
  input  logic [1:0]        srcASpec_i,
  input  logic [REG_AW-1:0] srcAId_i,
  input  logic              srcBUse_i,
  input  logic [1:0]        srcBSpec_i,
  input  logic [REG_AW-1:0] srcBId_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              loadStall_o,
`ifdef FWD_STALL_CNT_EN
  output logic [15:0]       stallCount_o,
`endif
  output logic [SELW-1:0]   forwardA_o,
  output logic [SELW-1:0]   forwardB_o
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              is_load;
    logic [1:0]        spec;
    logic [REG_AW-1:0] id;
  } tag_t;

  tag_t            tags [DEPTH];
  logic [SELW-1:0] sel_a, sel_b;
  logic            haz_a, haz_b;
  logic            issue;

  // Walk from oldest to youngest so the youngest match is the last writer.
  // Special-register classes compare on spec alone; GPRs also need the id.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch forms.
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (srcAUse_i && tags[k].valid && tags[k].reg_write &&
          tags[k].spec == srcASpec_i &&
          (srcASpec_i != 2'd0 || tags[k].id == srcAId_i)) begin
        sel_a = SELW'(k + 1);
        haz_a = tags[k].is_load && (k < LOAD_STAGE);
      end
      if (srcBUse_i && tags[k].valid && tags[k].reg_write &&
          tags[k].spec == srcBSpec_i &&
          (srcBSpec_i != 2'd0 || tags[k].id == srcBId_i)) begin
        sel_b = SELW'(k + 1);
        haz_b = tags[k].is_load && (k < LOAD_STAGE);
      end
    end
  end

  assign loadStall_o = idValid_i && !flush_i && (haz_a || haz_b);
  assign issue       = idValid_i && !flush_i && !loadStall_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: only the valid bits are cleared; the other tag fields are
      // don't-care while invalid, so they carry no reset.
      for (int k = 0; k < DEPTH; k++) tags[k].valid <= 1'b0;
      forwardA_o <= '0;
      forwardB_o <= '0;
    end else if (!hold_i) begin
      for (int k = 1; k < DEPTH; k++) tags[k] <= tags[k-1];
      if (issue) begin
        tags[0]    <= '{valid: 1'b1, reg_write: idRegWrite_i,
                        is_load: idIsLoad_i, spec: idDstSpec_i, id: idDstId_i};
        forwardA_o <= sel_a;
        forwardB_o <= sel_b;
      end else begin
        // Bubble: a stalled or flushed ID instruction leaves EX empty.
        tags[0].valid <= 1'b0;
        forwardA_o    <= '0;
        forwardB_o    <= '0;
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!hold_i && loadStall_o && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stallCount_o = stall_cnt;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
module tb_forward_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       idValid_i = 0, idRegWrite_i = 0, idIsLoad_i = 0;
  logic [1:0] idDstSpec_i = 0;
  logic [2:0] idDstId_i = 0;
  logic       srcAUse_i = 0, srcBUse_i = 0;
  logic [1:0] srcASpec_i = 0, srcBSpec_i = 0;
  logic [2:0] srcAId_i = 0, srcBId_i = 0;
  logic       hold_i = 0, flush_i = 0;
  logic       loadStall_o;
  logic [1:0] forwardA_o, forwardB_o;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stallCount_o;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  forward_scoreboard dut (
    .clk(clk), .rst(rst),
    .idValid_i(idValid_i), .idRegWrite_i(idRegWrite_i), .idIsLoad_i(idIsLoad_i),
    .idDstSpec_i(idDstSpec_i), .idDstId_i(idDstId_i),
    .srcAUse_i(srcAUse_i), .srcASpec_i(srcASpec_i), .srcAId_i(srcAId_i),
    .srcBUse_i(srcBUse_i), .srcBSpec_i(srcBSpec_i), .srcBId_i(srcBId_i),
    .hold_i(hold_i), .flush_i(flush_i), .loadStall_o(loadStall_o),
`ifdef FWD_STALL_CNT_EN
    .stallCount_o(stallCount_o),
`endif
    .forwardA_o(forwardA_o), .forwardB_o(forwardB_o)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the ID instruction, then let combinational outputs settle.
  task automatic id_op(input logic v, input logic rw, input logic ld,
                       input logic [1:0] ds, input logic [2:0] di,
                       input logic au, input logic [1:0] as, input logic [2:0] ai,
                       input logic bu, input logic [1:0] bs, input logic [2:0] bi);
    idValid_i = v;  idRegWrite_i = rw; idIsLoad_i = ld;
    idDstSpec_i = ds; idDstId_i = di;
    srcAUse_i = au; srcASpec_i = as; srcAId_i = ai;
    srcBUse_i = bu; srcBSpec_i = bs; srcBId_i = bi;
    #1;
  endtask

  task automatic alu(input logic [2:0] dst);
    id_op(1, 1, 0, 0, dst, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lw(input logic [2:0] dst);
    id_op(1, 1, 1, 0, dst, 0, 0, 0, 0, 0, 0);
  endtask

  // Consumer writing R4 reading GPR srcA.
  task automatic use_a(input logic [2:0] src);
    id_op(1, 1, 0, 0, 3'd4, 1, 0, src, 0, 0, 0);
  endtask

  initial begin
    // Reset with no activity.
    tick(); tick();
    check("rst_fwdA", 16'(forwardA_o), 0);
    check("rst_fwdB", 16'(forwardB_o), 0);
    check("rst_stall", 16'(loadStall_o), 0);
    rst = 1'b1;

    // Producer R3, N fillers, consumer srcA=R3.
    for (int n = 0; n < 4; n++) begin
      alu(3'd3); tick();
      for (int f = 0; f < n; f++) begin alu(3'd7); tick(); end
      use_a(3'd3);
      check($sformatf("gap%0d_stall", n), 16'(loadStall_o), 0);
      tick();
      check($sformatf("gap%0d_fwdA", n), 16'(forwardA_o), (n == 3) ? 16'd0 : 16'(n + 1));
    end

    // Youngest wins; unused srcA with matching id never forwards.
    alu(3'd3); tick();
    alu(3'd3); tick();
    id_op(1, 1, 0, 0, 3'd4, 0, 0, 3'd3, 1, 0, 3'd3);
    tick();
    check("young_fwdB", 16'(forwardB_o), 1);
    check("unused_fwdA", 16'(forwardA_o), 0);

    // Load-use: one stall, bubble, then forward from MEM.
    lw(3'd2); tick();
    use_a(3'd2);
    check("lu_stall", 16'(loadStall_o), 1);
    tick();
    check("lu_bub_fwdA", 16'(forwardA_o), 0);
    check("lu_bub_fwdB", 16'(forwardB_o), 0);
    check("lu_stall_off", 16'(loadStall_o), 0);
    tick();
    check("lu_fwdA", 16'(forwardA_o), 2);
`ifdef FWD_STALL_CNT_EN
    check("lu_cnt", stallCount_o, 1);
`endif

    // Special-register matching.
    id_op(1, 1, 0, 2'd2, 3'd0, 0, 0, 0, 0, 0, 0); tick();     // writes SP
    id_op(1, 1, 0, 0, 3'd4, 1, 2'd2, 3'd5, 0, 0, 0); tick();  // reads SP
    check("sp_fwdA", 16'(forwardA_o), 1);
    alu(3'd0); tick();                                        // writes R0
    id_op(1, 1, 0, 0, 3'd4, 1, 2'd1, 3'd0, 0, 0, 0); tick();  // reads T
    check("t_vs_r0_fwdA", 16'(forwardA_o), 0);
    id_op(1, 1, 0, 2'd1, 3'd3, 0, 0, 0, 0, 0, 0); tick();     // writes T
    use_a(3'd3); tick();                                      // reads R3
    check("r3_vs_t_fwdA", 16'(forwardA_o), 0);

    // Hold freezes entries and outputs.
    alu(3'd3); tick();
    id_op(1, 1, 0, 0, 3'd3, 1, 0, 3'd3, 0, 0, 0); tick();
    check("pre_hold_fwdA", 16'(forwardA_o), 1);
    hold_i = 1'b1;
    id_op(1, 1, 0, 0, 3'd4, 0, 0, 0, 1, 0, 3'd3);
    tick(); tick(); tick();
    check("hold_fwdA", 16'(forwardA_o), 1);
    check("hold_fwdB", 16'(forwardB_o), 0);
    hold_i = 1'b0;
    tick();
    check("resume_fwdA", 16'(forwardA_o), 0);
    check("resume_fwdB", 16'(forwardB_o), 1);

    // Stall is still evaluated under hold; counter ignores held cycles.
    lw(3'd2); tick();
    hold_i = 1'b1;
    use_a(3'd2);
    check("hold_stall", 16'(loadStall_o), 1);
    tick();
    check("hold_stall2", 16'(loadStall_o), 1);
    hold_i = 1'b0;
    #1;
    tick();
    check("hold_rel_stall", 16'(loadStall_o), 0);
    tick();
    check("hold_rel_fwdA", 16'(forwardA_o), 2);
`ifdef FWD_STALL_CNT_EN
    check("hold_cnt", stallCount_o, 2);
`endif

    // Flush suppresses the stall and inserts a bubble (flushed op writes R2).
    lw(3'd2); tick();
    flush_i = 1'b1;
    id_op(1, 1, 0, 0, 3'd2, 1, 0, 3'd2, 0, 0, 0);
    check("flush_stall", 16'(loadStall_o), 0);
    tick();
    check("flush_fwdA", 16'(forwardA_o), 0);
    flush_i = 1'b0;
    use_a(3'd2);
    check("post_flush_stall", 16'(loadStall_o), 0);
    tick();
    check("post_flush_fwdA", 16'(forwardA_o), 2);

    // Reset with three valid entries in flight.
    alu(3'd3); tick();
    id_op(1, 1, 0, 0, 3'd3, 1, 0, 3'd3, 0, 0, 0); tick();
    id_op(1, 1, 1, 0, 3'd3, 0, 0, 0, 1, 0, 3'd3); tick();
    check("pre_rst_fwdB", 16'(forwardB_o), 1);
    use_a(3'd3);
    check("pre_rst_stall", 16'(loadStall_o), 1);
    rst = 1'b0;
    tick();
    check("mid_rst_fwdA", 16'(forwardA_o), 0);
    check("mid_rst_fwdB", 16'(forwardB_o), 0);
    check("mid_rst_stall", 16'(loadStall_o), 0);
`ifdef FWD_STALL_CNT_EN
    check("rst_cnt", stallCount_o, 0);
`endif
    rst = 1'b1;
    tick();
    check("post_rst_fwdA", 16'(forwardA_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 3, GPR index width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked in-flight stages (EX=0, MEM=1, WB=2, ...); legal range 2..7.
REQ-003 SHALL have parameter LOAD_STAGE, default 1, first stage index whose load result is forwardable; legal range 1..DEPTH-1.
REQ-004 SHALL have derived parameter SELW = clog2(DEPTH+1), default 2.
REQ-005 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports idValid_i, idRegWrite_i, idIsLoad_i  in  1 each  ID-stage instruction valid, writes a register, is a load.
REQ-008 SHALL have ports idDstSpec_i  in  2 and idDstId_i  in  REG_AW  ID destination; spec 0 = GPR, 1..3 = T/SP/IH class, id ignored when spec != 0.
REQ-009 SHALL have ports srcAUse_i, srcBUse_i  in  1; srcASpec_i, srcBSpec_i  in  2; srcAId_i, srcBId_i  in  REG_AW  ID source operands.
REQ-010 SHALL have port hold_i  in  1  global pipeline freeze.
REQ-011 SHALL have port flush_i  in  1  kill the ID instruction.
REQ-012 SHALL have port loadStall_o  out  1  combinational load-use stall request.
REQ-013 SHALL have ports forwardA_o, forwardB_o  out  SELW  registered EX operand select: 0 = register file, k = stage k-1 pipeline register.

Function
REQ-014 SHALL keep DEPTH tag entries {valid, regWrite, isLoad, spec, id}; entry k describes the instruction in stage k.
REQ-015 Match SHALL be: srcUse && entry.valid && entry.regWrite && spec equal && (spec != 0 || id equal).
REQ-016 For each source, the lowest-index (youngest) matching entry k SHALL win; the select registered for EX SHALL be k+1, and 0 if none matches.
REQ-017 loadStall_o SHALL be 1 when idValid_i && !flush_i and either source's winning entry has isLoad=1 and index k < LOAD_STAGE.
REQ-018 Each non-hold cycle, entries 1..DEPTH-1 SHALL shift from k-1, and entry DEPTH-1's old contents SHALL be dropped.
REQ-019 Entry 0 SHALL load the ID tag when idValid_i && !flush_i && !loadStall_o; otherwise it SHALL load a bubble (valid=0).
REQ-020 forwardA_o/forwardB_o SHALL update with entry 0, taking the computed selects on a load and 0 on a bubble: one-cycle latency from ID to EX.
REQ-021 Priority SHALL be hold_i > flush_i > loadStall_o > normal issue.
REQ-022 hold_i=1 SHALL freeze all entries and outputs; loadStall_o SHALL still be evaluated combinationally.
REQ-023 After a load-use stall of LOAD_STAGE-k cycles, the same ID instruction SHALL issue with select >= LOAD_STAGE+1, with no extra bubble.
REQ-024 A srcUse=0 source SHALL never match, stall or forward.
REQ-025 A special-register source SHALL never match a GPR destination with an equal id, and vice versa.

Reset
REQ-026 With rst=0 at a clock edge, all entry valid bits, forwardA_o, forwardB_o and the stall counter SHALL become 0; in-flight tags SHALL be discarded mid-operation.
REQ-027 During and immediately after reset, loadStall_o SHALL be 0 because no entry is valid.

Configuration
REQ-028 Macro FWD_STALL_CNT_EN defined: SHALL add port stallCount_o  out  16, incremented by 1 on each non-hold edge with loadStall_o=1, saturating at 16'hFFFF, and cleared by reset.
REQ-029 Macro FWD_STALL_CNT_EN undefined: stallCount_o and the counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Defaults. ADD writes R3, next cycle srcA=R3 -> forwardA_o=1 at EX; a one-instruction gap gives 2; a two-instruction gap gives 3; a three-instruction gap gives 0.
REQ-031 R3 written by the instructions now in EX and MEM, srcB=R3 -> forwardB_o=1 (youngest wins).
REQ-032 LW R2 followed immediately by srcA=R2 -> loadStall_o=1 for one cycle, then a bubble in EX with selects 0, then issue with forwardA_o=2; stallCount_o=1.
REQ-033 Producer writes SP (spec=2), consumer srcA spec=2 id=5 -> forwardA_o=1; a producer writing GPR R0 with consumer srcA spec=1 id=0 -> forwardA_o=0.
REQ-034 hold_i=1 for 3 cycles mid-sequence -> tags and outputs unchanged; on release, the sequence resumes exactly. flush_i with a load hazard -> loadStall_o=0 and a bubble enters.
REQ-035 rst=0 asserted for one edge with 3 valid entries -> all selects 0 and loadStall_o=0; the next dependent instruction gets forward select 0.
